// File: rtl/max_pooling_layer.sv
`default_nettype none
// ============================================================================
// Module      : max_pooling_layer
// Description : Streaming 2x2 / stride-2 max pooling over rows of unsigned
//               elements. Even rows are buffered and each odd row is pooled
//               against the buffered row. A frame-done pulse follows the
//               last row of each frame.
// Revision    : 1.0 - initial release
// ============================================================================
module max_pooling_layer #(
    parameter int input_width  = 7,
    parameter int input_height = 7,
    parameter int data_size    = 256
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                enable,
    input  logic [data_size*input_width-1:0]    row_input_stream,
    input  logic                                row_input_valid,
    output logic [data_size*(input_width/2)-1:0] row_output_stream,
    output logic                                row_output_valid,
    output logic                                frame_done
);

    localparam int output_width  = input_width / 2;
    localparam int output_height = input_height / 2;

    localparam int c_cnt_w     = $clog2(input_height + 1);
    localparam int c_pair_bits = data_size * 2 * output_width;
    localparam int c_out_bits  = data_size * output_width;
    localparam logic [c_cnt_w-1:0] c_last_row = c_cnt_w'(input_height - 1);
    // An odd frame height leaves one unpaired row at the end of each frame.
    localparam bit c_has_tail = (input_height != 2 * output_height);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EVEN = 2'd1,
        WAIT_ODD  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [c_cnt_w-1:0]      row_cnt_q, row_cnt_d;
    logic [c_pair_bits-1:0]  row_buf_q, row_buf_d;
    logic [c_out_bits-1:0]   out_stream_q, out_stream_d;
    logic                    out_valid_q, out_valid_d;
    logic                    frame_done_q, frame_done_d;

    logic [c_out_bits-1:0]   w_pooled;
    logic                    w_last_row;

    // The unpaired last column of an odd-width row never feeds a window.
    if (input_width % 2 == 1) begin : g_odd_width
        logic unused_last_col;
        assign unused_last_col = ^row_input_stream[data_size*input_width-1 -: data_size];
    end

    function automatic logic [data_size-1:0] max2(
        input logic [data_size-1:0] a,
        input logic [data_size-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    assign w_last_row = (row_cnt_q == c_last_row);

    // Max over each 2x2 window formed by the buffered even row and the live row.
    always_comb begin
        w_pooled = '0;
        for (int j = 0; j < output_width; j++) begin
            w_pooled[j*data_size +: data_size] = max2(
                max2(row_buf_q[(2*j)*data_size +: data_size],
                     row_buf_q[(2*j+1)*data_size +: data_size]),
                max2(row_input_stream[(2*j)*data_size +: data_size],
                     row_input_stream[(2*j+1)*data_size +: data_size]));
        end
    end

    // Next-state logic: row acceptance, pairing, frame counting and pulses.
    always_comb begin
        state_d      = state_q;
        row_cnt_d    = row_cnt_q;
        row_buf_d    = row_buf_q;
        out_stream_d = out_stream_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;

        if (!enable) begin
            // Dropping enable abandons any half-filled pair and the frame position.
            state_d   = IDLE;
            row_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WAIT_EVEN;
                end
                WAIT_EVEN: begin
                    if (row_input_valid) begin
                        row_buf_d = row_input_stream[c_pair_bits-1:0];
                        if (c_has_tail && w_last_row) begin
                            frame_done_d = 1'b1;
                            row_cnt_d    = '0;
                            state_d      = WAIT_EVEN;
                        end else begin
                            row_cnt_d = row_cnt_q + c_cnt_w'(1);
                            state_d   = WAIT_ODD;
                        end
                    end
                end
                WAIT_ODD: begin
                    if (row_input_valid) begin
                        out_stream_d = w_pooled;
                        out_valid_d  = 1'b1;
                        state_d      = WAIT_EVEN;
                        if (w_last_row) begin
                            frame_done_d = 1'b1;
                            row_cnt_d    = '0;
                        end else begin
                            row_cnt_d = row_cnt_q + c_cnt_w'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            row_cnt_q    <= '0;
            row_buf_q    <= '0;
            out_stream_q <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_cnt_q    <= row_cnt_d;
            row_buf_q    <= row_buf_d;
            out_stream_q <= out_stream_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign row_output_stream = out_stream_q;
    assign row_output_valid  = out_valid_q;
    assign frame_done        = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_max_pooling_layer.sv
`default_nettype none
// ============================================================================
// Module      : tb_max_pooling_layer
// Description : Scoreboard bench for max_pooling_layer (4 wide, 5 high, 8 bit).
//               A reference model predicts every cycle's outputs; a monitor
//               pops and compares them on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_max_pooling_layer;

    localparam int c_w  = 4;
    localparam int c_h  = 5;
    localparam int c_ds = 8;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [31:0] row_input_stream;
    logic        row_input_valid;
    logic [15:0] row_output_stream;
    logic        row_output_valid;
    logic        frame_done;

    max_pooling_layer #(
        .input_width (c_w),
        .input_height(c_h),
        .data_size   (c_ds)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .row_input_stream (row_input_stream),
        .row_input_valid  (row_input_valid),
        .row_output_stream(row_output_stream),
        .row_output_valid (row_output_valid),
        .frame_done       (frame_done)
    );

    typedef struct {
        int          cyc;
        bit          v;
        bit          fd;
        logic [15:0] data;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    // Reference model state: frame position, readiness, buffered even row.
    bit          m_ready = 0;
    int          m_idx   = 0;
    int          m_prev[c_w];
    logic [15:0] m_out   = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    function automatic logic [31:0] pack(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    // Predicts what the DUT shows after the coming rising edge.
    task automatic model(input bit en, input bit rstn, input bit vld, input logic [31:0] row);
        exp_t e;
        int   cur[c_w];
        int   mx;
        e.cyc = cyc + 1;
        e.v   = 0;
        e.fd  = 0;
        if (!rstn) begin
            m_ready = 0;
            m_idx   = 0;
            m_out   = '0;
        end else if (!en) begin
            m_ready = 0;
            m_idx   = 0;
        end else begin
            if (m_ready && vld) begin
                for (int i = 0; i < c_w; i++) cur[i] = int'(row[8*i +: 8]);
                if (m_idx % 2 == 0) begin
                    m_prev = cur;
                end else begin
                    for (int j = 0; j < c_w / 2; j++) begin
                        mx = m_prev[2*j];
                        if (m_prev[2*j+1] > mx) mx = m_prev[2*j+1];
                        if (cur[2*j] > mx) mx = cur[2*j];
                        if (cur[2*j+1] > mx) mx = cur[2*j+1];
                        m_out[8*j +: 8] = 8'(mx);
                    end
                    e.v = 1;
                end
                if (m_idx == c_h - 1) begin
                    e.fd  = 1;
                    m_idx = 0;
                end else begin
                    m_idx++;
                end
            end
            m_ready = 1;
        end
        e.data = m_out;
        q.push_back(e);
    endtask

    task automatic step(input bit en, input bit rstn, input bit vld, input logic [31:0] row);
        enable           = en;
        rst_n            = rstn;
        row_input_valid  = vld;
        row_input_stream = row;
        model(en, rstn, vld, row);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 1, 0, $urandom);
    endtask

    // Monitor: one expectation per clock, compared on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                if (e.cyc != cyc) begin
                    errors++;
                    $display("FAIL sync: monitor cycle %0d, expectation for cycle %0d", cyc, e.cyc);
                end
                checks++;
                if (row_output_valid !== e.v) begin
                    errors++;
                    $display("FAIL row_output_valid @%0d: got %b want %b", cyc, row_output_valid, e.v);
                end
                checks++;
                if (frame_done !== e.fd) begin
                    errors++;
                    $display("FAIL frame_done @%0d: got %b want %b", cyc, frame_done, e.fd);
                end
                checks++;
                if (row_output_stream !== e.data) begin
                    errors++;
                    $display("FAIL row_output_stream @%0d: got %h want %h", cyc, row_output_stream, e.data);
                end
            end
        end
    end

    initial begin
        // Reset, then enable with a row offered in the transition cycle (ignored).
        step(1, 0, 1, pack(9, 9, 9, 9));
        step(0, 0, 0, '0);
        step(1, 1, 1, pack(200, 200, 200, 200));

        // Basic pair -> [5,9].
        step(1, 1, 1, pack(1, 5, 2, 3));
        step(1, 1, 1, pack(4, 0, 9, 7));
        idle(1);
        // Gap between even and odd rows -> [255,2].
        step(1, 1, 1, pack(0, 0, 2, 0));
        idle(3);
        step(1, 1, 1, pack(255, 0, 0, 1));
        idle(2);
        // Unpaired final row: frame_done only.
        step(1, 1, 1, pack(77, 88, 99, 66));
        idle(2);

        // Back-to-back full frame of random rows.
        for (int i = 0; i < c_h; i++) step(1, 1, 1, $urandom);
        idle(2);

        // Enable drop after an even row, with a row offered as it falls.
        step(1, 1, 1, pack(250, 250, 250, 250));
        step(0, 1, 1, pack(240, 240, 240, 240));
        step(1, 1, 0, '0);
        step(1, 1, 1, pack(1, 1, 1, 1));
        step(1, 1, 1, pack(2, 2, 2, 2));
        idle(2);

        // Reset while waiting for the odd row.
        step(0, 1, 0, '0);
        step(1, 1, 0, '0);
        step(1, 1, 1, pack(230, 230, 230, 230));
        step(1, 0, 1, pack(3, 3, 3, 3));
        step(1, 1, 0, '0);
        step(1, 1, 1, pack(10, 20, 30, 40));
        step(1, 1, 1, pack(15, 5, 35, 25));
        idle(2);

        // Randomized traffic with occasional enable drops and resets.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 19) != 0, $urandom_range(0, 59) != 0,
                 1'($urandom_range(0, 2) != 0), $urandom);
        end
        idle(3);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
